// File: rtl/i2c_byte_receiver_if.sv
// ----------------------------------------------------------------------------
// i2c_byte_receiver_if
//   Bundles the bit-counter / pad inputs and the register-file facing outputs
//   of the I2C subordinate receive stage.
//   master : drives start/stop/count/sda/rx_ready, observes receiver outputs
//   slave  : the receiver itself
// ----------------------------------------------------------------------------
interface i2c_byte_receiver_if;
    logic       start;       // start / repeated-start flag
    logic       stop;        // stop condition flag
    logic [3:0] count;       // bit index: 0..7 data MSB first, 8 = ACK slot
    logic       sda;         // sampled SDA line
    logic       rx_ready;    // register file can take a byte
    logic [7:0] rx_byte;     // last completed write-data byte
    logic       byte_valid;  // one-cycle pulse when rx_byte updates
    logic       addr_match;  // addressed and still selected
    logic       rw;          // R/W bit of matched address (1 = read)
    logic       ack_en;      // pad pulls SDA low while high
    logic       nack_flag;   // sticky: a data byte was NACKed
    logic [7:0] byte_cnt;    // ACKed write bytes this transaction

    modport master (
        output start, stop, count, sda, rx_ready,
        input  rx_byte, byte_valid, addr_match, rw, ack_en, nack_flag, byte_cnt
    );

    modport slave (
        input  start, stop, count, sda, rx_ready,
        output rx_byte, byte_valid, addr_match, rw, ack_en, nack_flag, byte_cnt
    );
endinterface

// File: rtl/i2c_byte_receiver.sv
// ----------------------------------------------------------------------------
// i2c_byte_receiver
//   Subordinate-side receive stage downstream of the SCL bit counter. Shifts
//   SDA in MSB first, matches the 7-bit address against ADDR, raises ack_en
//   for the ACK slot and hands write bytes to the register file.
//   Ports:
//     scl  - clock, everything happens on posedge scl
//     rst  - synchronous active-high reset (highest priority)
//     bus  - i2c_byte_receiver_if.slave (flags, count, sda, rx_ready, outputs)
// ----------------------------------------------------------------------------
module i2c_byte_receiver #(
    parameter logic [6:0] ADDR      = 7'h42,
    parameter logic [7:0] MAX_BYTES = 8'd255
) (
    input  logic                  scl,
    input  logic                  rst,
    i2c_byte_receiver_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, ADDRS, WRITE, READ_PASS, IGNORE} state_t;

    state_t     state_q;
    logic [6:0] shreg_q;        // only the 7 most recent bits are ever needed
    logic [7:0] rx_byte_q;
    logic       byte_valid_q;
    logic       addr_match_q;
    logic       rw_q;
    logic       ack_en_q;
    logic       nack_flag_q;
    logic [7:0] byte_cnt_q;

    // Full byte as it stands once the bit at count==7 is sampled.
    logic [7:0] byte_d;
    assign byte_d = {shreg_q, bus.sda};

    always_ff @(posedge scl) begin
        byte_valid_q <= 1'b0;
        ack_en_q     <= 1'b0;
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            rx_byte_q    <= '0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            nack_flag_q  <= 1'b0;
            byte_cnt_q   <= '0;
        end else if (bus.start) begin
            // The start edge carries no data bit.
            state_q      <= ADDRS;
            shreg_q      <= '0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            nack_flag_q  <= 1'b0;
            byte_cnt_q   <= '0;
        end else if (bus.stop) begin
            state_q      <= IDLE;
            addr_match_q <= 1'b0;
        end else if (bus.count <= 4'd8) begin
            // count 9..15 is a counter glitch: no shift, no state change.
            unique case (state_q)
                ADDRS: begin
                    if (bus.count < 4'd7) begin
                        shreg_q <= byte_d[6:0];
                    end else if (bus.count == 4'd7) begin
                        if (byte_d[7:1] == ADDR) begin
                            addr_match_q <= 1'b1;
                            rw_q         <= byte_d[0];
                            ack_en_q     <= 1'b1;
                            state_q      <= byte_d[0] ? READ_PASS : WRITE;
                        end else begin
                            state_q <= IGNORE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.count < 4'd7) begin
                        shreg_q <= byte_d[6:0];
                    end else if (bus.count == 4'd7) begin
                        // The byte is delivered even when it is going to be NACKed.
                        rx_byte_q    <= byte_d;
                        byte_valid_q <= 1'b1;
                        if (bus.rx_ready) begin
                            ack_en_q <= 1'b1;
                            if (byte_cnt_q != MAX_BYTES) byte_cnt_q <= byte_cnt_q + 8'd1;
                        end else begin
                            nack_flag_q  <= 1'b1;
                            addr_match_q <= 1'b0;
                            state_q      <= IGNORE;
                        end
                    end
                end
                default: ;  // IDLE, READ_PASS, IGNORE only leave via start/stop/rst
            endcase
        end
    end

    assign bus.rx_byte    = rx_byte_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.addr_match = addr_match_q;
    assign bus.rw         = rw_q;
    assign bus.ack_en     = ack_en_q;
    assign bus.nack_flag  = nack_flag_q;
    assign bus.byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_i2c_byte_receiver.sv
// ----------------------------------------------------------------------------
// tb_i2c_byte_receiver
//   Directed and randomized transactions checked against a transaction-level
//   model: each byte's expected outcome is decided from the address/ready
//   rules before its bits are driven.
// ----------------------------------------------------------------------------
module tb_i2c_byte_receiver;
    localparam logic [6:0] A = 7'h42;

    logic scl = 1'b0;
    logic rst;
    always #5 scl = ~scl;

    i2c_byte_receiver_if bus ();

    i2c_byte_receiver #(.ADDR(A), .MAX_BYTES(8'd255)) dut (
        .scl (scl),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Transaction model. phase: 0 unselected/idle, 1 expecting address byte,
    // 2 accepting write data, 3 read selected, 4 dropped until next start.
    int         m_phase;
    logic       m_match, m_rw, m_nack;
    logic [7:0] m_rx, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic st, input logic sp, input logic [3:0] c, input logic d);
        @(negedge scl);
        bus.start = st;
        bus.stop  = sp;
        bus.count = c;
        bus.sda   = d;
        @(posedge scl);
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".addr_match"}, bus.addr_match, m_match);
        chk({tag, ".rw"},         bus.rw,         m_rw);
        chk({tag, ".nack_flag"},  bus.nack_flag,  m_nack);
        chk({tag, ".byte_cnt"},   bus.byte_cnt,   m_cnt);
        chk({tag, ".rx_byte"},    bus.rx_byte,    m_rx);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
        rst = 1'b0;
        m_phase = 0; m_match = 0; m_rw = 0; m_nack = 0; m_rx = 0; m_cnt = 0;
        chk_state("reset");
        chk("reset.ack_en", bus.ack_en, 1'b0);
        chk("reset.byte_valid", bus.byte_valid, 1'b0);
    endtask

    task automatic do_start();
        tick(1'b1, 1'b0, 4'($urandom), 1'($urandom));
        m_phase = 1; m_match = 0; m_rw = 0; m_nack = 0; m_cnt = 0;
        chk_state("start");
        chk("start.ack_en", bus.ack_en, 1'b0);
    endtask

    task automatic do_stop();
        tick(1'b0, 1'b1, 4'($urandom), 1'($urandom));
        m_phase = 0; m_match = 0;
        chk_state("stop");
        chk("stop.ack_en", bus.ack_en, 1'b0);
    endtask

    // Bits of an unfinished byte (later cut off by start or reset).
    task automatic partial(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'(i), 1'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ready);
        logic exp_ack, exp_valid;
        int   jp;
        exp_ack = 1'b0; exp_valid = 1'b0;
        if (m_phase == 1) begin
            if (b[7:1] == A) begin
                exp_ack = 1'b1; m_match = 1'b1; m_rw = b[0];
                m_phase = b[0] ? 3 : 2;
            end else begin
                m_phase = 4;
            end
        end else if (m_phase == 2) begin
            exp_valid = 1'b1; m_rx = b;
            if (ready) begin
                exp_ack = 1'b1;
                if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            end else begin
                m_nack = 1'b1; m_match = 1'b0; m_phase = 4;
            end
        end
        bus.rx_ready = ready;
        jp = $urandom_range(0, 15);  // sometimes slip in an out-of-range count
        for (int i = 0; i < 8; i++) begin
            if (i == jp) tick(1'b0, 1'b0, 4'($urandom_range(9, 15)), 1'($urandom));
            tick(1'b0, 1'b0, 4'(i), b[7-i]);
        end
        chk("bit7.ack_en", bus.ack_en, exp_ack);
        chk("bit7.byte_valid", bus.byte_valid, exp_valid);
        tick(1'b0, 1'b0, 4'd8, 1'($urandom));
        chk("ack.ack_en", bus.ack_en, 1'b0);
        chk("ack.byte_valid", bus.byte_valid, 1'b0);
        chk_state("byte");
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.count = 4'd0;
        bus.sda = 1'b0; bus.rx_ready = 1'b1;
        do_reset();

        // Matched write, two accepted bytes, then backpressure.
        do_start();
        send_byte(8'h84, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        chk("write2.byte_cnt", bus.byte_cnt, 8'd2);
        send_byte(8'h11, 1'b0);
        chk("nack.rx_byte", bus.rx_byte, 8'h11);
        chk("nack.flag", bus.nack_flag, 1'b1);
        send_byte(8'h55, 1'b1);

        // Repeated start mid-byte, then a read address.
        partial(4);
        do_start();
        send_byte(8'h85, 1'b1);
        chk("read.rw", bus.rw, 1'b1);
        send_byte(8'h77, 1'b1);
        do_stop();
        chk("read.stop_rw", bus.rw, 1'b1);

        // Address mismatch.
        do_start();
        send_byte(8'h86, 1'b1);
        send_byte(8'hFF, 1'b1);
        do_stop();

        // Idle ignores traffic.
        send_byte(8'h84, 1'b1);

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            int n;
            logic [7:0] a;
            do_start();
            a = ($urandom_range(0, 3) != 0) ? {A, 1'($urandom)} : 8'($urandom);
            send_byte(a, 1'b1);
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) send_byte(8'($urandom), $urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) partial($urandom_range(0, 7));
            else do_stop();
        end

        // Byte counter saturation.
        do_start();
        send_byte({A, 1'b0}, 1'b1);
        for (int k = 0; k < 257; k++) send_byte(8'($urandom), 1'b1);
        chk("sat.byte_cnt", bus.byte_cnt, 8'd255);

        // Reset in the middle of a transfer, then bits without a start.
        partial(3);
        do_reset();
        send_byte(8'h84, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
